tm1638_responder: RTL
=====================

Name: tm1638_responder

Overview:
- Synthesizable model of the TM1638 chip side of the serial link driven by the tm1638 controller. Lets the controller be exercised on hardware loopback and in simulation without a real chip.
- Deserialises STB/CLK/DIO frames LSB-first and decodes the data, address and display-control commands.
- Holds the 16-byte display RAM and the display state, and serialises a 4-byte key-scan snapshot back on DIO for read commands.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers on stb, sclk and dio_in (legal range 2..4).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- stb  in  1  frame strobe from the controller, active-low.
- sclk  in  1  serial clock from the controller; idle high.
- dio_in  in  1  serial data from the controller (its dio_out).
- dio_out  out  1  serial data to the controller (its dio_in).
- dio_oe  out  1  1 = responder is driving DIO.
- keys  in  32  key-scan bytes; byte n = keys[8n+7:8n].
- disp_raddr  in  4  display RAM read address.
- disp_rdata  out  8  display RAM data at disp_raddr; registered, 1-cycle latency.
- display_on  out  1  display enable from the last display-control command.
- brightness  out  3  pulse-width setting from the last display-control command.
- cmd_strobe  out  1  1-cycle pulse when a command byte has been decoded.
- frame_err  out  1  1-cycle pulse when stb rises with a partial byte (1..7 bits) received.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Synchronisers: stb, sclk and dio_in each pass through SYNC_STAGES flops. Edges are detected on the synchronised copies.
- Rising/falling sclk and stb edges are acted on SYNC_STAGES+1 clk after the pin edge.
- Timing requirement: sclk high and low phases must each be at least SYNC_STAGES+2 clk.
- Reset: dio_out=1, dio_oe=0, display_on=0, brightness=0, cmd_strobe=0, frame_err=0, disp_rdata=0.
  - All 16 RAM bytes clear to 0x00 (reset walks the RAM over 16 cycles; disp_rdata reads 0 throughout).
  - Address pointer=0, auto-increment mode, write mode, FSM=IDLE.
- FSM states: IDLE, CMD, WDATA, RDATA.
- IDLE -> CMD on stb falling edge; bit counter cleared.
- Bit reception: on sclk rising edge while stb low, shift dio_in into the byte register LSB-first. The byte completes on the 8th rising edge.
- Command byte decode (in CMD), pulsing cmd_strobe:
  - bits[7:6]=01 (data command): bit1 selects read (1) or write (0) mode; bit2 selects fixed (1) or auto-increment (0) addressing.
    - Write mode -> WDATA (extra bytes in this frame are ignored).
    - Read mode -> RDATA.
  - bits[7:6]=11 (address command): pointer=bits[3:0] -> WDATA.
  - bits[7:6]=10 (display control): display_on=bit3, brightness=bits[2:0] -> WDATA (extra bytes ignored).
  - bits[7:6]=00: ignored -> WDATA (extra bytes ignored).
- WDATA after an address command: each completed byte is written to RAM[pointer].
  - Auto-increment mode: pointer+1 mod 16 (15 wraps to 0).
  - Fixed mode: pointer unchanged.
- RDATA:
  - Entry: keys is snapshotted, byte index=0, bit index=0, dio_oe=1, dio_out=keys[0], all on the entry cycle.
  - On each sclk falling edge, advance one bit and update dio_out.
  - After 32 bits, dio_out=0 for all further bits while dio_oe stays 1.
  - Rising edges in RDATA do not shift the input register.
- stb rising edge, from any state -> IDLE: dio_oe=0, dio_out=1, bit counter cleared.
  - If 1..7 bits were pending: the partial byte is discarded and frame_err pulses.
  - Pointer and mode persist across frames.
- stb rising and a byte-completing sclk rise in the same cycle: the byte completes first, then the frame closes.
- rst asserted mid-frame: immediate return to reset state. Frame resumes only after stb goes high and falls again.
- disp_rdata = RAM[disp_raddr] registered. Read-during-write of the same address returns the old value.

Test Plan:
- Reset then frames {0x40}, {0xC0,0x11,0x22,0x33} -> RAM[0..2]=0x11,0x22,0x33, pointer=3, cmd_strobe pulses twice, frame_err never pulses.
- Frames {0x44}, {0xC5,0xAA,0xBB} -> RAM[5]=0xBB, RAM[6] stays 0x00 (fixed addressing).
- Frames {0xCF,0x01,0x02} in auto mode -> RAM[15]=0x01, RAM[0]=0x02 (wrap-around).
- Frame {0x8C} -> display_on=1, brightness=4; then {0x80} -> display_on=0, brightness=0.
- keys=0x55AA_F00F, frame {0x42} then 40 sclk pulses:
  - Sampled on sclk rising edges, LSB-first, the bytes read are 0x0F, 0xF0, 0xAA, 0x55, 0x00.
  - dio_oe falls within SYNC_STAGES+2 clk of stb rising.
- stb raised after 5 bits of {0xC3} -> frame_err one pulse, pointer unchanged.
  - Assert rst mid-read -> dio_oe=0 next cycle, RAM all 0x00 after 16 cycles.

Source files
------------

// File: rtl/tm1638_responder_if.sv
// Serial link between a TM1638 controller (master) and the chip side (slave).
// dio_in/dio_out are named from the chip's point of view.
interface tm1638_responder_if;
    logic stb;
    logic sclk;
    logic dio_in;
    logic dio_out;
    logic dio_oe;

    modport master (
        output stb,
        output sclk,
        output dio_in,
        input  dio_out,
        input  dio_oe
    );

    modport slave (
        input  stb,
        input  sclk,
        input  dio_in,
        output dio_out,
        output dio_oe
    );
endinterface

// File: rtl/tm1638_responder.sv
// Chip-side model of a TM1638: decodes LSB-first command/data frames into a
// 16-byte display RAM and display state, and shifts key-scan bytes back on reads.
module tm1638_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    tm1638_responder_if.slave    bus,
    input  logic [31:0]          keys,
    input  logic [3:0]           disp_raddr,
    output logic [7:0]           disp_rdata,
    output logic                 display_on,
    output logic [2:0]           brightness,
    output logic                 cmd_strobe,
    output logic                 frame_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CMD   = 2'd1;
    localparam logic [1:0] ST_WDATA = 2'd2;
    localparam logic [1:0] ST_RDATA = 2'd3;

    // Synchronisers keep tracking through reset so that a strobe already low
    // when reset drops is not mistaken for a new frame start.
    logic [SYNC_STAGES-1:0] stb_sync_reg;
    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] dio_sync_reg;
    logic                   stb_prev_reg;
    logic                   sclk_prev_reg;

    always_ff @(posedge clk) begin
        stb_sync_reg  <= {stb_sync_reg[SYNC_STAGES-2:0], bus.stb};
        sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], bus.sclk};
        dio_sync_reg  <= {dio_sync_reg[SYNC_STAGES-2:0], bus.dio_in};
        stb_prev_reg  <= stb_sync_reg[SYNC_STAGES-1];
        sclk_prev_reg <= sclk_sync_reg[SYNC_STAGES-1];
    end

    logic stb_cur, sclk_cur, dio_cur;
    logic stb_fall, stb_rise, sclk_rise, sclk_fall;

    assign stb_cur   = stb_sync_reg[SYNC_STAGES-1];
    assign sclk_cur  = sclk_sync_reg[SYNC_STAGES-1];
    assign dio_cur   = dio_sync_reg[SYNC_STAGES-1];
    assign stb_fall  = stb_prev_reg & ~stb_cur;
    assign stb_rise  = ~stb_prev_reg & stb_cur;
    assign sclk_rise = ~sclk_prev_reg & sclk_cur;
    assign sclk_fall = sclk_prev_reg & ~sclk_cur;

    logic [1:0]  state_reg, state_next;
    logic [2:0]  bit_cnt_reg, bit_cnt_next;
    logic [6:0]  shift_reg, shift_next;
    logic [3:0]  pointer_reg, pointer_next;
    logic        fixed_mode_reg, fixed_mode_next;
    logic        wr_arm_reg, wr_arm_next;
    logic        display_on_reg, display_on_next;
    logic [2:0]  brightness_reg, brightness_next;
    logic        cmd_strobe_reg, cmd_strobe_next;
    logic        frame_err_reg, frame_err_next;
    logic        dio_out_reg, dio_out_next;
    logic        dio_oe_reg, dio_oe_next;
    logic [31:0] key_snap_reg, key_snap_next;
    logic [5:0]  rd_idx_reg, rd_idx_next;
    logic        clear_active_reg;
    logic [3:0]  clear_addr_reg;
    logic [7:0]  disp_rdata_reg;
    logic        frame_we;
    logic [7:0]  rx_byte;

    // Only 7 bits are held; the 8th arrives on the completing edge.
    assign rx_byte = {dio_cur, shift_reg};

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        pointer_next    = pointer_reg;
        fixed_mode_next = fixed_mode_reg;
        wr_arm_next     = wr_arm_reg;
        display_on_next = display_on_reg;
        brightness_next = brightness_reg;
        cmd_strobe_next = 1'b0;
        frame_err_next  = 1'b0;
        dio_out_next    = dio_out_reg;
        dio_oe_next     = dio_oe_reg;
        key_snap_next   = key_snap_reg;
        rd_idx_next     = rd_idx_reg;
        frame_we        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (stb_fall) begin
                    state_next   = ST_CMD;
                    bit_cnt_next = 3'd0;
                    wr_arm_next  = 1'b0;
                end
            end
            ST_CMD, ST_WDATA: begin
                if (sclk_rise) begin
                    shift_next   = rx_byte[7:1];
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        if (state_reg == ST_CMD) begin
                            cmd_strobe_next = 1'b1;
                            state_next      = ST_WDATA;
                            case (rx_byte[7:6])
                                2'b01: begin
                                    fixed_mode_next = rx_byte[2];
                                    if (rx_byte[1]) begin
                                        state_next    = ST_RDATA;
                                        key_snap_next = keys;
                                        rd_idx_next   = 6'd0;
                                        dio_oe_next   = 1'b1;
                                        dio_out_next  = keys[0];
                                    end
                                end
                                2'b11: begin
                                    pointer_next = rx_byte[3:0];
                                    wr_arm_next  = 1'b1;
                                end
                                2'b10: begin
                                    display_on_next = rx_byte[3];
                                    brightness_next = rx_byte[2:0];
                                end
                                default: ;
                            endcase
                        end else if (wr_arm_reg) begin
                            frame_we = 1'b1;
                            if (!fixed_mode_reg)
                                pointer_next = pointer_reg + 4'd1;
                        end
                    end
                end
            end
            default: begin
                // Bit 0 is already on the pin at entry, so each falling edge
                // presents the bit at the current index and then advances.
                if (sclk_fall) begin
                    if (!rd_idx_reg[5]) begin
                        dio_out_next = key_snap_reg[rd_idx_reg[4:0]];
                        rd_idx_next  = rd_idx_reg + 6'd1;
                    end else begin
                        dio_out_next = 1'b0;
                    end
                end
            end
        endcase

        // Frame close overrides everything above, after a completing byte has been taken.
        if (stb_rise) begin
            frame_err_next = (bit_cnt_next != 3'd0);
            state_next     = ST_IDLE;
            bit_cnt_next   = 3'd0;
            dio_oe_next    = 1'b0;
            dio_out_next   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            bit_cnt_reg      <= 3'd0;
            shift_reg        <= 7'd0;
            pointer_reg      <= 4'd0;
            fixed_mode_reg   <= 1'b0;
            wr_arm_reg       <= 1'b0;
            display_on_reg   <= 1'b0;
            brightness_reg   <= 3'd0;
            cmd_strobe_reg   <= 1'b0;
            frame_err_reg    <= 1'b0;
            dio_out_reg      <= 1'b1;
            dio_oe_reg       <= 1'b0;
            key_snap_reg     <= 32'd0;
            rd_idx_reg       <= 6'd0;
            clear_active_reg <= 1'b1;
            clear_addr_reg   <= 4'd0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            pointer_reg    <= pointer_next;
            fixed_mode_reg <= fixed_mode_next;
            wr_arm_reg     <= wr_arm_next;
            display_on_reg <= display_on_next;
            brightness_reg <= brightness_next;
            cmd_strobe_reg <= cmd_strobe_next;
            frame_err_reg  <= frame_err_next;
            dio_out_reg    <= dio_out_next;
            dio_oe_reg     <= dio_oe_next;
            key_snap_reg   <= key_snap_next;
            rd_idx_reg     <= rd_idx_next;
            if (clear_active_reg) begin
                clear_addr_reg <= clear_addr_reg + 4'd1;
                if (clear_addr_reg == 4'd15)
                    clear_active_reg <= 1'b0;
            end
        end
    end

    // Display RAM: the post-reset clear walk owns the single write port.
    logic [7:0] ram_mem [16];
    logic       ram_we;
    logic [3:0] ram_waddr;
    logic [7:0] ram_wdata;

    assign ram_we    = clear_active_reg | (frame_we & ~rst);
    assign ram_waddr = clear_active_reg ? clear_addr_reg : pointer_reg;
    assign ram_wdata = clear_active_reg ? 8'h00 : rx_byte;

    always_ff @(posedge clk) begin
        if (ram_we)
            ram_mem[ram_waddr] <= ram_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst || clear_active_reg)
            disp_rdata_reg <= 8'h00;
        else
            disp_rdata_reg <= ram_mem[disp_raddr];
    end

    assign bus.dio_out = dio_out_reg;
    assign bus.dio_oe  = dio_oe_reg;
    assign disp_rdata  = disp_rdata_reg;
    assign display_on  = display_on_reg;
    assign brightness  = brightness_reg;
    assign cmd_strobe  = cmd_strobe_reg;
    assign frame_err   = frame_err_reg;

endmodule
